mx_regfile_wb: RTL and testbench
================================

Name: mx_regfile_wb

Overview:
- Write-back register file at the far end of the SEU register bus.
- Accepts write-back requests (data_line, load_addr, load_en) from the scalar execution unit and queues them.
- Retires queued requests one register per cycle into a 16x8 array, and drives the committed array back as reg_line.
- Provides a host init port and a stall signal so the upstream sequencer can hold fetch.

Parameters:
- NREGS, 16, number of registers and data_line lanes (power of two).
- WIDTH, 8, register width in bits.
- QDEPTH, 2, write-request queue depth (entries).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_line  input  NREGS x WIDTH  result lanes from the SEU; lane i targets register i.
- load_addr  input  8  [3:0] base register B; [7:4] burst length minus one N (1..16 registers).
- load_en  input  1  write-back request strobe, sampled on clk.
- host_we  input  1  host direct write strobe.
- host_addr  input  4  host write register index.
- host_wdata  input  WIDTH  host write data.
- reg_line  output  NREGS x WIDTH  committed register contents (registered).
- stall  output  1  queue full; upstream must not assert load_en.
- busy  output  1  queue non-empty (writes pending).
- overflow  output  1  sticky: a load_en arrived while stall=1.

Behaviour:
- Reset (rst=1 at an edge): all registers 0, queue emptied, burst offset k=0, reg_line=0, stall=0, busy=0, overflow=0. An in-flight burst is abandoned; no later writes from it occur.
- Enqueue: at an edge with load_en=1 and stall=0, push {B, N, snapshot of all data_line lanes}.
  - Push with stall=1 is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- stall = (count == QDEPTH); busy = (count != 0). Both are combinational from the registered count.
- Drain:
  - While busy and host_we=0, each edge writes reg[(B+k) mod NREGS] <= snapshot lane [(B+k) mod NREGS], then k increments.
  - When k == N, that write is the last: pop the head entry and reset k to 0.
  - An entry covers N+1 consecutive edges with no host collision. The next entry starts on the following edge with no bubble.
- Latency: an entry accepted at edge t performs its first register write at edge t+1, visible on reg_line after t+1.
  - If accepted into an empty queue, the entry is eligible immediately at t+1.
- Wrap-around: the register index wraps modulo NREGS. B=14, N=3 writes 14, 15, 0, 1. N=15 writes all 16 registers starting at B.
- Host port:
  - host_we=1 writes reg[host_addr] <= host_wdata at that edge.
  - Host has priority: the drain pauses that cycle (k and the queue are unchanged).
  - Enqueue still proceeds normally during a host write.
  - A queued drain write to the same register issued later overwrites the host value.
- Simultaneous push and pop (not full): count unchanged; the new entry sits behind the head.
- Data snapshot: data_line is captured at enqueue. Later changes on data_line do not affect queued entries.
- reg_line is the register array itself; it changes only on clk edges.

Test Plan:
- Reset: registers preloaded via host, then rst=1 for 1 cycle -> reg_line all 0; stall=0, busy=0, overflow=0.
- Single write: load_en with load_addr=8'h05, lane5=8'hA7 -> reg5=8'hA7 after the next edge; busy high exactly 1 cycle; other registers unchanged.
- Wrapping burst: load_addr=8'h3E (B=14, N=3), lanes 14, 15, 0, 1 = 11, 22, 33, 44 (hex) -> written on 4 consecutive edges in order 14, 15, 0, 1; then busy=0.
- Queue full: two bursts of N=7 back-to-back, then a third load_en -> stall=1 after the second push; third request dropped; overflow=1; first 16 writes complete and no third-burst data appears.
- Host collision: burst B=0, N=2 with host_we=1 (addr 1, data 8'hFF) on the second drain cycle -> drain pauses one cycle; reg1 ends as the burst lane1 value; total burst duration 4 cycles.
- Reset mid-burst: B=0, N=15 in progress at k=5, assert rst -> all registers 0; busy=0 on the next cycle; no further writes occur.

Source files
------------

// File: rtl/mx_regfile_wb.sv
// Write-back register file: queues multi-register write-back bursts from the
// scalar execution unit and retires them one register per cycle, with a host
// port that can write directly and pre-empt the drain for a cycle.
module mx_regfile_wb #(
   parameter int NREGS  = 16,
   parameter int WIDTH  = 8,
   parameter int QDEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREGS-1:0][WIDTH-1:0]  data_line,
   input  logic [7:0]                   load_addr,
   input  logic                         load_en,
   input  logic                         host_we,
   input  logic [3:0]                   host_addr,
   input  logic [WIDTH-1:0]             host_wdata,
   output logic [NREGS-1:0][WIDTH-1:0]  reg_line,
   output logic                         stall,
   output logic                         busy,
   output logic                         overflow
);

   localparam int AW = $clog2(NREGS);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   // Request queue storage: base register, burst length minus one, lane snapshot
   logic [3:0]                  q_base [QDEPTH];
   logic [3:0]                  q_len  [QDEPTH];
   logic [NREGS-1:0][WIDTH-1:0] q_data [QDEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [3:0]    k;

   logic          push;
   logic          drain;
   logic          last;
   logic [AW-1:0] idx;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign stall = (count == CW'(QDEPTH));
   assign busy  = (count != '0);
   assign push  = load_en & ~stall;
   assign drain = busy & ~host_we;
   assign last  = drain & (k == q_len[head]);
   assign idx   = AW'(q_base[head] + k);

   // Capture the request fields and a full lane snapshot into the tail slot
   always_ff @(posedge clk) begin
      if (push) begin
         q_base[tail] <= load_addr[3:0];
         q_len[tail]  <= load_addr[7:4];
         q_data[tail] <= data_line;
      end
   end

   // Queue pointers, occupancy, burst offset and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         k        <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            tail <= next_ptr(tail);
         end
         if (last) begin
            head <= next_ptr(head);
         end
         case ({push, last})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (last) begin
            k <= '0;
         end else if (drain) begin
            k <= k + 4'd1;
         end
         if (load_en && stall) begin
            overflow <= 1'b1;
         end
      end
   end

   // Committed register array: host write wins, otherwise retire one queued lane
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_line <= '0;
      end else if (host_we) begin
         reg_line[host_addr[AW-1:0]] <= host_wdata;
      end else if (busy) begin
         reg_line[idx] <= q_data[head][idx];
      end
   end

endmodule

// File: tb/tb_mx_regfile_wb.sv
// Self-checking bench for mx_regfile_wb: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_mx_regfile_wb;

   localparam int NR = 16;
   localparam int W  = 8;
   localparam int QD = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NR-1:0][W-1:0]   data_line;
   logic [7:0]             load_addr;
   logic                   load_en;
   logic                   host_we;
   logic [3:0]             host_addr;
   logic [W-1:0]           host_wdata;
   logic [NR-1:0][W-1:0]   reg_line;
   logic                   stall;
   logic                   busy;
   logic                   overflow;

   mx_regfile_wb #(.NREGS(NR), .WIDTH(W), .QDEPTH(QD)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_line  (data_line),
      .load_addr  (load_addr),
      .load_en    (load_en),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .reg_line   (reg_line),
      .stall      (stall),
      .busy       (busy),
      .overflow   (overflow)
   );

   // Free-running clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]           b;
      logic [3:0]           n;
      logic [NR-1:0][W-1:0] d;
   } entry_t;

   entry_t               mq[$];
   logic [NR-1:0][W-1:0] m_reg;
   int                   mk;
   logic                 m_ovf;
   bit                   model_valid = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance the reference model by one clock edge using the inputs just applied
   task automatic modelStep();
      bit     was_full;
      int     r;
      entry_t e;
      if (rst) begin
         m_reg = '0;
         mq.delete();
         mk = 0;
         m_ovf = 1'b0;
         model_valid = 1'b1;
      end else begin
         was_full = (mq.size() == QD);
         if (host_we) begin
            m_reg[host_addr] = host_wdata;
         end else if (mq.size() != 0) begin
            r = (int'(mq[0].b) + mk) % NR;
            m_reg[r] = mq[0].d[r];
            if (mk == int'(mq[0].n)) begin
               void'(mq.pop_front());
               mk = 0;
            end else begin
               mk++;
            end
         end
         if (load_en) begin
            if (was_full) begin
               m_ovf = 1'b1;
            end else begin
               e.b = load_addr[3:0];
               e.n = load_addr[7:4];
               e.d = data_line;
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic le, input logic [7:0] la, input logic [NR-1:0][W-1:0] dl,
                                input logic hwe, input logic [3:0] ha, input logic [W-1:0] hd, input logic r);
      @(negedge clk);
      load_en    = le;
      load_addr  = la;
      data_line  = dl;
      host_we    = hwe;
      host_addr  = ha;
      host_wdata = hd;
      rst        = r;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 8'h00, data_line, 1'b0, 4'h0, 8'h00, 1'b0);
      end
   endtask

   // Every cycle once reset has been seen, compare the DUT against the model
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("reg_line", reg_line, m_reg);
         checkOutput("stall", stall, (mq.size() == QD));
         checkOutput("busy", busy, (mq.size() != 0));
         checkOutput("overflow", overflow, m_ovf);
      end
   end

   initial begin
      logic [NR-1:0][W-1:0] dl;
      rst = 1'b1;
      load_en = 1'b0;
      load_addr = '0;
      data_line = '0;
      host_we = 1'b0;
      host_addr = '0;
      host_wdata = '0;
      dl = '0;

      // Reset, preload a few registers via host, reset again
      applyStimulus(1'b0, 8'h00, dl, 1'b0, 4'h0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, dl, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0);
      end
      checkOutput("preload_reg2", reg_line[2], 8'h12);
      applyStimulus(1'b0, 8'h00, dl, 1'b0, 4'h0, 8'h00, 1'b1);
      checkOutput("reset_regs", reg_line, 128'h0);
      checkOutput("reset_flags", {stall, busy, overflow}, 3'b000);

      // Single-register write-back
      for (int i = 0; i < NR; i++) dl[i] = 8'($urandom);
      dl[5] = 8'hA7;
      applyStimulus(1'b1, 8'h05, dl, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("single_busy_on", busy, 1'b1);
      idle(1);
      checkOutput("single_reg5", reg_line[5], 8'hA7);
      checkOutput("single_busy_off", busy, 1'b0);
      checkOutput("single_reg4", reg_line[4], 8'h00);

      // Wrapping burst B=14 N=3
      dl[14] = 8'h11; dl[15] = 8'h22; dl[0] = 8'h33; dl[1] = 8'h44;
      applyStimulus(1'b1, 8'h3E, dl, 1'b0, 4'h0, 8'h00, 1'b0);
      idle(1);
      checkOutput("wrap_r14", reg_line[14], 8'h11);
      checkOutput("wrap_r15_pending", reg_line[15], 8'h00);
      idle(1);
      checkOutput("wrap_r15", reg_line[15], 8'h22);
      idle(1);
      checkOutput("wrap_r0", reg_line[0], 8'h33);
      checkOutput("wrap_r1_pending", reg_line[1], 8'h00);
      idle(1);
      checkOutput("wrap_r1", reg_line[1], 8'h44);
      checkOutput("wrap_busy_off", busy, 1'b0);

      // Queue full: two N=7 bursts, third request dropped
      for (int i = 0; i < NR; i++) dl[i] = 8'(8'h50 + i);
      for (int i = 8; i < NR; i++) dl[i] = 8'(8'h60 + i - 8);
      applyStimulus(1'b1, 8'h70, dl, 1'b0, 4'h0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h78, dl, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("full_stall", stall, 1'b1);
      applyStimulus(1'b1, 8'h70, {NR{8'hEE}}, 1'b0, 4'h0, 8'h00, 1'b0);
      checkOutput("full_overflow", overflow, 1'b1);
      idle(16);
      checkOutput("full_r3", reg_line[3], 8'h53);
      checkOutput("full_r12", reg_line[12], 8'h64);
      checkOutput("full_r0_not_third", reg_line[0], 8'h50);
      checkOutput("full_busy_off", busy, 1'b0);

      // Host collision on the second drain cycle
      applyStimulus(1'b0, 8'h00, dl, 1'b0, 4'h0, 8'h00, 1'b1);
      dl[0] = 8'hA1; dl[1] = 8'hB2; dl[2] = 8'hC3;
      applyStimulus(1'b1, 8'h20, dl, 1'b0, 4'h0, 8'h00, 1'b0);
      idle(1);
      applyStimulus(1'b0, 8'h00, dl, 1'b1, 4'h1, 8'hFF, 1'b0);
      checkOutput("host_r1_ff", reg_line[1], 8'hFF);
      idle(1);
      checkOutput("host_r1_burst", reg_line[1], 8'hB2);
      checkOutput("host_busy_3", busy, 1'b1);
      idle(1);
      checkOutput("host_r2", reg_line[2], 8'hC3);
      checkOutput("host_busy_4", busy, 1'b0);

      // Reset in the middle of a full-width burst
      applyStimulus(1'b1, 8'hF0, {NR{8'h77}}, 1'b0, 4'h0, 8'h00, 1'b0);
      idle(5);
      checkOutput("mid_r4", reg_line[4], 8'h77);
      applyStimulus(1'b0, 8'h00, dl, 1'b0, 4'h0, 8'h00, 1'b1);
      checkOutput("mid_reset_regs", reg_line, 128'h0);
      checkOutput("mid_reset_busy", busy, 1'b0);
      idle(20);
      checkOutput("mid_no_late_writes", reg_line, 128'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         logic [7:0] la;
         for (int i = 0; i < NR; i++) dl[i] = 8'($urandom);
         la = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 3)), 4'($urandom)};
         applyStimulus($urandom_range(0, 2) == 0, la, dl,
                       $urandom_range(0, 5) == 0, 4'($urandom), 8'($urandom),
                       $urandom_range(0, 149) == 0);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
